// File: rtl/pipeline_deliver_chain.sv
// pipeline_deliver_chain: DEPTH-slot payload/valid register chain placed
// between pipeline stages. It keeps the producer/consumer stall semantics at
// its ends, adds a synchronous flush, lets internal bubbles collapse, and
// reports how many slots hold a valid entry.
module pipeline_deliver_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall_current_stage,
    input  logic                       stall_next_stage,
    input  logic                       valid_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       ready_out,
    output logic                       valid_out,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    // v[k] / d[k]: slot k valid and payload; d[k] is kept zero while v[k]=0
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0]            adv;
    logic                        load_valid;

    // Advance chain: a slot loads when it is empty or its occupant moves on.
    // With DEPTH=1 the single slot holds whenever the consumer stalls, so the
    // legacy register behaviour is kept; with DEPTH>1 an empty output slot
    // still fills under stall so the chain can hold DEPTH entries.
    always_comb begin : advance_chain
        logic chain;
        chain = !stall_next_stage;
        if (DEPTH > 1) begin
            chain = chain | !v[DEPTH-1];
        end
        adv          = '0;
        adv[DEPTH-1] = chain;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            chain              = chain | !v[DEPTH-1-i];
            adv[DEPTH-1-i]     = chain;
        end
    end

    // Entry qualifier: a stalled producer injects a bubble instead of data
    always_comb begin
        load_valid = !stall_current_stage & valid_in;
    end

    // Slot registers: async reset, then flush, then normal shift/load/hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            d <= '0;
        end else if (flush) begin
            v <= '0;
            d <= '0;
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
            end
            if (adv[0]) begin
                v[0] <= load_valid;
                d[0] <= load_valid ? data_in : '0;
            end
        end
    end

    // Boundary outputs: output slot and producer handshake
    always_comb begin
        ready_out = adv[0] & !stall_current_stage & !flush;
        valid_out = v[DEPTH-1];
        data_out  = d[DEPTH-1];
    end

    // Occupancy: popcount of the registered valid bits
    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

endmodule
